uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the line driven by the team's UART transmitter (`UART_T`) and recovers its frames at one bit per clock. It sits directly downstream of the transmitter on the same clock. It deserialises each frame into a `D_WIDTH`-bit word, checks the stop bit, and presents the word on a valid/ready output with overrun and framing-error reporting.

## Interface
- `D_WIDTH`, 13: data bits per frame.
- `C_WIDTH`, 5: bit-counter width; the design requires 2^C_WIDTH > D_WIDTH.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-low (0 at a rising edge resets).
- `rx`  in  1  serial line, idle high; same clock domain, no synchroniser.
- `rx_data`  out  D_WIDTH  received word, D0 = first data bit on the line.
- `rx_valid`  out  1  rx_data holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- `rx_busy`  out  1  high in every state except RX_IDLE.
- `rx_overrun`  out  1  one-cycle pulse: a good frame was dropped because the holding register was full.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low, frame discarded.

## Operation
- Line format (matches the transmitter): idle 1; start 0 (1 cycle); D0..D(D_WIDTH-1), LSB first, 1 cycle each; stop 1 (≥1 cycle).
- Reset values: state RX_SYNC, bit counter 0, shift register 0, rx_data 0, rx_valid 0, rx_overrun 0, rx_frame_err 0, rx_busy 1 (because the state is not RX_IDLE).
- RX_SYNC: waits for rx==1 at an edge, then goes to RX_IDLE. A reset in mid-frame therefore never mistakes a data 0 for a start bit.
- RX_IDLE: rx==0 at an edge → RX_DATA, counter 0.
- RX_DATA: each edge shifts rx into the MSB of the shift register (right shift) and increments the counter. After bit D_WIDTH-1 is sampled → RX_STOP.
- RX_STOP, rx==1: frame good → RX_IDLE, and the word is offered to the holding register.
- RX_STOP, rx==0: rx_frame_err pulses, the word is discarded → RX_BREAK.
- RX_BREAK: waits for rx==1, then → RX_IDLE. The line being high at the exit edge does not count as a start.
- Holding register, on a good frame:
  - If !rx_valid, or rx_valid && rx_ready in the same cycle: load the word, rx_valid=1.
  - Otherwise: keep the old word and pulse rx_overrun.
- With no new word, a handshake (rx_valid && rx_ready) clears rx_valid. rx_data keeps its last value.
- rx_ready is ignored while rx_valid is 0.
- Counter arithmetic is unsigned C_WIDTH and never wraps within a frame.

## Timing
- Start sampled at edge k.
- Data bit Di sampled at edge k+1+i.
- Stop sampled at edge k+D_WIDTH+1, which is k+14 at the defaults.
- rx_valid, rx_overrun and rx_frame_err are registered and visible right after the stop-sample edge. Latency from start edge to rx_valid is D_WIDTH+1 cycles.
- Back-to-back frames are supported: a start at edge k+D_WIDTH+2 (one stop cycle) is accepted.
- Reset has priority over every other event in the same cycle, including a pending handshake or completing frame.
- rx_valid must not drop without a handshake. rx_data must not change while rx_valid && !rx_ready.

## Structure
- Package `uart_pkg` holds:
  - default localparams `UART_D_WIDTH`=13 and `UART_C_WIDTH`=5;
  - the state typedef `uart_rx_state_t` {RX_SYNC, RX_IDLE, RX_DATA, RX_STOP, RX_BREAK}.
- The transmitter's defaults are to be migrated to the same package.
- One sub-module, `uart_rx_hold`: the 1-entry valid/ready holding register with overrun detection. The top level contains the FSM, counter and shift register.

## Test plan
- **Reset and sync:** hold rst=0 for 3 cycles with rx=0, release with rx=0 for 5 cycles, then rx=1 → no start detected, rx_valid=0, rx_busy=1 until the first rx=1 edge.
- **Single frame:** send 0x0A5B, rx_ready=1 → rx_valid high for 1 cycle, exactly 14 cycles after the start edge, with rx_data=0x0A5B.
- **Back-to-back:** frames 0x1FFF, 0x0000, 0x1555 with 1-cycle stops, rx_ready=1 → three words delivered in order, 15 cycles apart, with no errors.
- **Overrun:** rx_ready=0, send 0x0123 then 0x0456 → rx_data stays 0x0123 and rx_overrun pulses once at the second stop. Raise rx_ready → one handshake, then rx_valid=0.
- **Handshake collision:** rx_ready rises on the same edge the second frame completes → 0x0456 is loaded, rx_valid stays 1, no overrun.
- **Framing error:** send 0x00FF with the stop forced to 0 for 4 cycles, then idle, then 0x0042 → rx_frame_err pulses once, nothing is delivered for the bad frame, and 0x0042 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and types for the UART transmitter/receiver pair.
//   UART_D_WIDTH : data bits per frame (used by both UART_T and uart_rx)
//   UART_C_WIDTH : bit-counter width, 2**UART_C_WIDTH must exceed UART_D_WIDTH
//   uart_rx_state_t : receiver FSM states
package uart_pkg;

  localparam int UART_D_WIDTH = 13;
  localparam int UART_C_WIDTH = 5;

  typedef enum logic [2:0] {
    RX_SYNC,
    RX_IDLE,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in plus the valid/ready word output of the receiver.
//   rx           : serial line, idle high
//   rx_data      : received word, D0 = first data bit
//   rx_valid     : rx_data holds an unconsumed word
//   rx_ready     : consumer accepts when rx_valid && rx_ready
//   rx_busy      : receiver not idle
//   rx_overrun   : one-cycle pulse, good frame dropped (holding register full)
//   rx_frame_err : one-cycle pulse, stop bit sampled low
// slave = receiver side, master = line driver / consumer side.
interface uart_rx_if import uart_pkg::*; #(
  parameter int D_WIDTH = UART_D_WIDTH
);
  logic               rx;
  logic [D_WIDTH-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               rx_busy;
  logic               rx_overrun;
  logic               rx_frame_err;

  modport slave (
    input  rx, rx_ready,
    output rx_data, rx_valid, rx_busy, rx_overrun, rx_frame_err
  );

  modport master (
    output rx, rx_ready,
    input  rx_data, rx_valid, rx_busy, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/uart_rx_hold.sv
// uart_rx_hold: 1-entry valid/ready holding register with overrun detection.
//   clk, rst   : clock, synchronous active-low reset
//   i_load     : a good frame completed this cycle, i_word is offered
//   i_word     : completed word
//   i_ready    : consumer ready
//   o_data     : held word (keeps last value after consumption)
//   o_valid    : o_data is unconsumed
//   o_overrun  : one-cycle pulse, offered word dropped because entry was full
module uart_rx_hold import uart_pkg::*; #(
  parameter int D_WIDTH = UART_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [D_WIDTH-1:0] i_word,
  input  logic               i_ready,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_overrun
);

  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_overrun;
  logic               w_hs;

  assign w_hs = r_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        // A same-cycle handshake frees the entry, so the new word fits.
        if (!r_valid || w_hs) begin
          r_data  <= i_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: one-bit-per-clock UART frame receiver.
//   clk : clock, all state updates on rising edge
//   rst : synchronous active-low reset
//   bus : uart_rx_if.slave (rx in, rx_ready in; rx_data/rx_valid/rx_busy/
//         rx_overrun/rx_frame_err out)
// Frame: start 0, D0..D(D_WIDTH-1) LSB first, stop 1, one cycle per bit.
// C_WIDTH must satisfy 2**C_WIDTH > D_WIDTH.
module uart_rx import uart_pkg::*; #(
  parameter int D_WIDTH = UART_D_WIDTH,
  parameter int C_WIDTH = UART_C_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  uart_rx_state_t     r_state;
  uart_rx_state_t     w_next;
  logic [C_WIDTH-1:0] r_cnt;
  logic [D_WIDTH-1:0] r_shift;
  logic               r_frame_err;

  logic               w_last;
  logic               w_busy;
  logic               w_good;
  logic               w_bad;
  logic [D_WIDTH-1:0] w_data;
  logic               w_valid;
  logic               w_overrun;

  assign w_last = (r_cnt == C_WIDTH'(D_WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RX_SYNC;
    else      r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_SYNC:  if (bus.rx)  w_next = RX_IDLE;
      RX_IDLE:  if (!bus.rx) w_next = RX_DATA;
      RX_DATA:  if (w_last)  w_next = RX_STOP;
      RX_STOP:  w_next = bus.rx ? RX_IDLE : RX_BREAK;
      // Leaving on a high line: the exit edge itself is never a start.
      RX_BREAK: if (bus.rx)  w_next = RX_IDLE;
      default:  w_next = RX_SYNC;
    endcase
  end

  // Outputs
  always_comb begin
    w_busy = (r_state != RX_IDLE);
    w_good = (r_state == RX_STOP) &&  bus.rx;
    w_bad  = (r_state == RX_STOP) && !bus.rx;
  end

  // Bit counter and shift register; shift in at MSB so D0 ends at bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (r_state == RX_IDLE) begin
      r_cnt   <= '0;
    end else if (r_state == RX_DATA) begin
      r_shift <= {bus.rx, r_shift[D_WIDTH-1:1]};
      r_cnt   <= r_cnt + C_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_frame_err <= 1'b0;
    else      r_frame_err <= w_bad;
  end

  uart_rx_hold #(.D_WIDTH(D_WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_good),
    .i_word    (r_shift),
    .i_ready   (bus.rx_ready),
    .o_data    (w_data),
    .o_valid   (w_valid),
    .o_overrun (w_overrun)
  );

  assign bus.rx_data      = w_data;
  assign bus.rx_valid     = w_valid;
  assign bus.rx_overrun   = w_overrun;
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW = UART_D_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.D_WIDTH(DW)) bus();

  uart_rx #(.D_WIDTH(DW), .C_WIDTH(UART_C_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int            gap;   // idle cycles (ready=1) before the frame
    logic          rdy;   // rx_ready during the frame
    logic [DW-1:0] d;     // word sent
    logic          pre;   // rx_valid after last data edge
    logic          v;     // rx_valid after stop edge
    logic [DW-1:0] xd;    // rx_data after stop edge
    logic          ovr;   // rx_overrun after stop edge
  } vec_t;

  vec_t tbl [6];
  logic pre;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    tick();
  endtask

  // Start, data LSB first, then stop; rx_ready takes rdy_stop at the stop edge.
  task automatic send(input logic [DW-1:0] d, input logic stop_b,
                      input logic rdy_stop, output logic pre_v);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    pre_v = bus.rx_valid;
    bus.rx_ready = rdy_stop;
    drive_bit(stop_b);
  endtask

  initial begin
    tbl[0] = '{2, 1'b1, 13'h0A5B, 1'b0, 1'b1, 13'h0A5B, 1'b0};
    tbl[1] = '{0, 1'b1, 13'h1FFF, 1'b0, 1'b1, 13'h1FFF, 1'b0};
    tbl[2] = '{0, 1'b1, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0};
    tbl[3] = '{0, 1'b1, 13'h1555, 1'b0, 1'b1, 13'h1555, 1'b0};
    tbl[4] = '{2, 1'b0, 13'h0123, 1'b0, 1'b1, 13'h0123, 1'b0};
    tbl[5] = '{0, 1'b0, 13'h0456, 1'b1, 1'b1, 13'h0123, 1'b1};

    // Reset and sync: line low through and after reset
    bus.rx = 1'b0;
    bus.rx_ready = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst valid", bus.rx_valid, 0);
    chk("rst data", bus.rx_data, 0);
    chk("rst busy", bus.rx_busy, 1);
    chk("rst ovr", bus.rx_overrun, 0);
    chk("rst ferr", bus.rx_frame_err, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0);
      chk($sformatf("sync busy %0d", i), bus.rx_busy, 1);
      chk($sformatf("sync valid %0d", i), bus.rx_valid, 0);
    end
    drive_bit(1'b1);
    chk("sync idle", bus.rx_busy, 0);

    // Table: single frame, back-to-back frames, overrun pair
    for (int i = 0; i < 6; i++) begin
      bus.rx_ready = 1'b1;
      repeat (tbl[i].gap) drive_bit(1'b1);
      bus.rx_ready = tbl[i].rdy;
      send(tbl[i].d, 1'b1, tbl[i].rdy, pre);
      chk($sformatf("v%0d pre", i), pre, tbl[i].pre);
      chk($sformatf("v%0d valid", i), bus.rx_valid, tbl[i].v);
      chk($sformatf("v%0d data", i), bus.rx_data, tbl[i].xd);
      chk($sformatf("v%0d ovr", i), bus.rx_overrun, tbl[i].ovr);
      chk($sformatf("v%0d ferr", i), bus.rx_frame_err, 0);
      chk($sformatf("v%0d busy", i), bus.rx_busy, 0);
    end

    // Overrun drain: one handshake then empty
    bus.rx_ready = 1'b1;
    drive_bit(1'b1);
    chk("ovr drain valid", bus.rx_valid, 0);
    chk("ovr drain data", bus.rx_data, 13'h0123);
    chk("ovr pulse end", bus.rx_overrun, 0);
    drive_bit(1'b1);
    chk("ovr idle valid", bus.rx_valid, 0);

    // Handshake collision at the completing edge
    bus.rx_ready = 1'b0;
    send(13'h0123, 1'b1, 1'b0, pre);
    chk("col first valid", bus.rx_valid, 1);
    send(13'h0456, 1'b1, 1'b1, pre);
    chk("col pre", pre, 1);
    chk("col valid", bus.rx_valid, 1);
    chk("col data", bus.rx_data, 13'h0456);
    chk("col ovr", bus.rx_overrun, 0);
    drive_bit(1'b1);
    chk("col drain", bus.rx_valid, 0);

    // Framing error: stop low for 4 cycles, idle, then a good frame
    send(13'h00FF, 1'b0, 1'b1, pre);
    chk("fe pulse", bus.rx_frame_err, 1);
    chk("fe valid", bus.rx_valid, 0);
    chk("fe busy", bus.rx_busy, 1);
    repeat (3) drive_bit(1'b0);
    chk("fe pulse end", bus.rx_frame_err, 0);
    chk("fe brk busy", bus.rx_busy, 1);
    chk("fe brk valid", bus.rx_valid, 0);
    drive_bit(1'b1);
    chk("fe exit idle", bus.rx_busy, 0);
    drive_bit(1'b1);
    chk("fe no start", bus.rx_busy, 0);
    chk("fe data kept", bus.rx_data, 13'h0456);
    send(13'h0042, 1'b1, 1'b1, pre);
    chk("fe next valid", bus.rx_valid, 1);
    chk("fe next data", bus.rx_data, 13'h0042);
    chk("fe next ferr", bus.rx_frame_err, 0);
    drive_bit(1'b1);
    chk("fe next drain", bus.rx_valid, 0);

    // Reset wins over a completing frame
    bus.rx_ready = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(1'b1);
    rst = 1'b0;
    bus.rx_ready = 1'b1;
    drive_bit(1'b1);
    chk("rprio valid", bus.rx_valid, 0);
    chk("rprio data", bus.rx_data, 0);
    chk("rprio busy", bus.rx_busy, 1);
    rst = 1'b1;
    drive_bit(1'b1);
    chk("rprio sync", bus.rx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
